// File: rtl/kernel_vec_map_top.sv
// kernel_vec_map_top: NLANES-wide elementwise binary map (add/mul/sub) through a
// LAT-stage valid/ready pipeline, with an output beat counter and a per-frame
// done pulse. All stages advance together on a single global enable.
module kernel_vec_map_top #(
  parameter int STREAMW = 32,
  parameter int NLANES  = 4,
  parameter int LAT     = 3,
  parameter int OP      = 0,
  parameter int NELEM   = 1024,
  parameter int CNTW    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ivalid,
  output logic                        iready,
  input  logic [NLANES*STREAMW-1:0]   in_a,
  input  logic [NLANES*STREAMW-1:0]   in_b,
  output logic                        ovalid,
  input  logic                        oready,
  output logic [NLANES*STREAMW-1:0]   out_v,
  output logic [CNTW-1:0]             beat_cnt,
  output logic                        done
);

  localparam int VW = NLANES * STREAMW;

  // Parameter sanity checks, evaluated at elaboration.
  if (OP < 0 || OP > 2) begin : g_bad_op
    $error("kernel_vec_map_top: OP must be 0 (add), 1 (mul) or 2 (sub)");
  end
  if (LAT < 1 || LAT > 8) begin : g_bad_lat
    $error("kernel_vec_map_top: LAT must be in 1..8");
  end
  if (NELEM < 1 || (longint'(1) << CNTW) < longint'(NELEM)) begin : g_bad_cnt
    $error("kernel_vec_map_top: need NELEM >= 1 and 2**CNTW >= NELEM");
  end

  logic          en;
  logic          xfer_in;
  logic          xfer_out;
  logic [VW-1:0] op_res;
  logic [LAT-1:0] stg_vld;
  logic [VW-1:0] stg_dat [LAT];

  // The whole pipeline moves when the output slot is empty or being drained.
  // iready is therefore combinational from ovalid/oready.
  assign en       = ~ovalid | oready;
  assign iready   = en & ~rst;
  assign xfer_in  = ivalid & iready;
  assign xfer_out = ovalid & oready;

  assign ovalid = stg_vld[LAT-1];
  assign out_v  = stg_dat[LAT-1];

  // Lane-wise operation; results truncate to STREAMW bits, no cross-lane carry.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    op_res = '0;
    for (int i = 0; i < NLANES; i++) begin
      case (OP)
        0:       op_res[i*STREAMW +: STREAMW] = in_a[i*STREAMW +: STREAMW] + in_b[i*STREAMW +: STREAMW];
        1:       op_res[i*STREAMW +: STREAMW] = in_a[i*STREAMW +: STREAMW] * in_b[i*STREAMW +: STREAMW];
        default: op_res[i*STREAMW +: STREAMW] = in_a[i*STREAMW +: STREAMW] - in_b[i*STREAMW +: STREAMW];
      endcase
    end
  end

  // Pipeline stages: stage 0 captures the result, later stages only delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_vld <= '0;
      // NOTE: the data registers are cleared too because out_v must read zero after
      // reset; this is a small register pipeline, not a RAM, so the reset is cheap.
      for (int i = 0; i < LAT; i++) stg_dat[i] <= '0;
    end else if (en) begin
      // NOTE: non-blocking assignments let every stage read its predecessor's old value.
      stg_vld[0] <= xfer_in;
      stg_dat[0] <= op_res;
      for (int i = 1; i < LAT; i++) begin
        stg_vld[i] <= stg_vld[i-1];
        stg_dat[i] <= stg_dat[i-1];
      end
    end
  end

  // Output beat counter and registered end-of-frame pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (xfer_out) begin
        if (beat_cnt == CNTW'(NELEM - 1)) begin
          beat_cnt <= '0;
          done     <= 1'b1;
        end else begin
          beat_cnt <= beat_cnt + CNTW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_kernel_vec_map_top.sv
// Self-checking bench for kernel_vec_map_top. Three instances (add, mul, sub) share
// one stimulus stream; a queue-based reference model predicts every output beat,
// the beat counter and the done pulse from the arithmetic and handshake rules.
module tb_kernel_vec_map_top;

  localparam int SW = 32;
  localparam int NL = 4;
  localparam int VW = NL * SW;
  localparam int CW = 16;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ivalid = 1'b0;
  logic oready = 1'b0;
  logic [VW-1:0] in_a = '0;
  logic [VW-1:0] in_b = '0;

  logic          iready   [ND];
  logic          ovalid   [ND];
  logic          done     [ND];
  logic [VW-1:0] out_v    [ND];
  logic [CW-1:0] beat_cnt [ND];

  always #5 clk = ~clk;

  kernel_vec_map_top #(.STREAMW(SW), .NLANES(NL), .LAT(3), .OP(0), .NELEM(4), .CNTW(CW)) u_add (
    .clk(clk), .rst(rst), .ivalid(ivalid), .iready(iready[0]), .in_a(in_a), .in_b(in_b),
    .ovalid(ovalid[0]), .oready(oready), .out_v(out_v[0]), .beat_cnt(beat_cnt[0]), .done(done[0]));
  kernel_vec_map_top #(.STREAMW(SW), .NLANES(NL), .LAT(3), .OP(1), .NELEM(1024), .CNTW(CW)) u_mul (
    .clk(clk), .rst(rst), .ivalid(ivalid), .iready(iready[1]), .in_a(in_a), .in_b(in_b),
    .ovalid(ovalid[1]), .oready(oready), .out_v(out_v[1]), .beat_cnt(beat_cnt[1]), .done(done[1]));
  kernel_vec_map_top #(.STREAMW(SW), .NLANES(NL), .LAT(3), .OP(2), .NELEM(1), .CNTW(CW)) u_sub (
    .clk(clk), .rst(rst), .ivalid(ivalid), .iready(iready[2]), .in_a(in_a), .in_b(in_b),
    .ovalid(ovalid[2]), .oready(oready), .out_v(out_v[2]), .beat_cnt(beat_cnt[2]), .done(done[2]));

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [VW-1:0] exp_q [ND][$];
  int            cnt_m  [ND];
  bit            done_m [ND];
  int            nel    [ND] = '{4, 1024, 1};
  int            opc    [ND] = '{0, 1, 2};
  bit            mon_en = 1'b0;
  bit            acc;
  bit            xfer   [ND];
  logic [VW-1:0] last_out0;

  function automatic logic [VW-1:0] pack(logic [31:0] l0, logic [31:0] l1,
                                         logic [31:0] l2, logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [VW-1:0] ref_op(int op, logic [VW-1:0] a, logic [VW-1:0] b);
    logic [VW-1:0]   r;
    longint unsigned x, y, z, m;
    r = '0;
    m = 64'd1 << SW;
    for (int l = 0; l < NL; l++) begin
      x = 64'(a[l*SW +: SW]);
      y = 64'(b[l*SW +: SW]);
      case (op)
        0:       z = (x + y) % m;
        1:       z = (x * y) % m;
        default: z = (x + m - y) % m;
      endcase
      r[l*SW +: SW] = z[SW-1:0];
    end
    return r;
  endfunction

  task automatic check(string tag, logic [VW-1:0] obs, logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit all_empty();
    return exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0;
  endfunction

  // One clock cycle: at the falling edge compare outputs with the model and predict
  // the effect of the coming rising edge; return 1 ns after that rising edge.
  task automatic tick();
    @(negedge clk);
    acc = 1'b0;
    for (int d = 0; d < ND; d++) begin
      xfer[d] = 1'b0;
      if (mon_en) begin
        check($sformatf("iready[%0d]", d), VW'(iready[d]), VW'(!rst && (!ovalid[d] || oready)));
        check($sformatf("beat_cnt[%0d]", d), VW'(beat_cnt[d]), VW'(cnt_m[d]));
        check($sformatf("done[%0d]", d), VW'(done[d]), VW'(done_m[d]));
      end
      if (rst) begin
        exp_q[d].delete();
        cnt_m[d]  = 0;
        done_m[d] = 1'b0;
      end else begin
        done_m[d] = 1'b0;
        if (ovalid[d] === 1'b1 && oready) begin
          xfer[d] = 1'b1;
          if (d == 0) last_out0 = out_v[0];
          check($sformatf("q_nonempty[%0d]", d), VW'(exp_q[d].size() != 0), VW'(1));
          if (exp_q[d].size() != 0)
            check($sformatf("out_v[%0d]", d), out_v[d], exp_q[d].pop_front());
          if (cnt_m[d] == nel[d] - 1) begin
            cnt_m[d]  = 0;
            done_m[d] = 1'b1;
          end else begin
            cnt_m[d]++;
          end
        end
        if (ivalid && iready[d] === 1'b1) begin
          exp_q[d].push_back(ref_op(opc[d], in_a, in_b));
          if (d == 0) acc = 1'b1;
        end
      end
    end
    if (rst) mon_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(logic [VW-1:0] a, logic [VW-1:0] b);
    ivalid = 1'b1;
    in_a   = a;
    in_b   = b;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (acc) break;
    end
    check("send_accepted", VW'(acc), VW'(1));
    ivalid = 1'b0;
  endtask

  task automatic drain();
    ivalid = 1'b0;
    oready = 1'b1;
    for (int i = 0; i < 50 && !all_empty(); i++) tick();
    tick();
    check("drain_empty", VW'(exp_q[0].size()), VW'(0));
  endtask

  initial begin
    int n;
    int k;
    int n_out;
    logic [VW-1:0] held;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    for (int d = 0; d < ND; d++) begin
      check($sformatf("rst_iready[%0d]", d), VW'(iready[d]), VW'(0));
      check($sformatf("rst_ovalid[%0d]", d), VW'(ovalid[d]), VW'(0));
      check($sformatf("rst_out_v[%0d]", d), out_v[d], VW'(0));
      check($sformatf("rst_beat_cnt[%0d]", d), VW'(beat_cnt[d]), VW'(0));
      check($sformatf("rst_done[%0d]", d), VW'(done[d]), VW'(0));
    end
    rst = 1'b0;

    // Single beat and latency: visible two edges after acceptance
    oready = 1'b1;
    ivalid = 1'b1;
    in_a   = pack(1, 2, 3, 4);
    in_b   = pack(10, 20, 30, 40);
    tick();
    check("lat_accept", VW'(acc), VW'(1));
    ivalid = 1'b0;
    check("lat_edge_k", VW'(ovalid[0]), VW'(0));
    tick();
    check("lat_edge_k1", VW'(ovalid[0]), VW'(0));
    tick();
    check("lat_edge_k2_valid", VW'(ovalid[0]), VW'(1));
    check("lat_edge_k2_data", out_v[0], pack(11, 22, 33, 44));
    tick();
    check("single_beat_cnt", VW'(beat_cnt[0]), VW'(1));
    check("single_after_ovalid", VW'(ovalid[0]), VW'(0));

    // Wrap arithmetic, lane independence
    ivalid = 1'b1;
    in_a   = pack(32'hFFFF_FFFF, 32'h0, 32'h1_0000, 32'd5);
    in_b   = pack(32'd2, 32'd1, 32'h1_0000, 32'd3);
    tick();
    ivalid = 1'b0;
    tick();
    tick();
    check("wrap_add_lane0", VW'(out_v[0][0 +: SW]), VW'(32'h1));
    check("wrap_add_lane3", VW'(out_v[0][3*SW +: SW]), VW'(32'd8));
    check("wrap_mul_lane2", VW'(out_v[1][2*SW +: SW]), VW'(32'h0));
    check("wrap_mul_lane3", VW'(out_v[1][3*SW +: SW]), VW'(32'd15));
    check("wrap_sub_lane1", VW'(out_v[2][1*SW +: SW]), VW'(32'hFFFF_FFFF));
    check("wrap_sub_lane3", VW'(out_v[2][3*SW +: SW]), VW'(32'd2));
    tick();

    // Back-pressure: 10 beats of value 0..9, oready low for cycles 4..8
    n = 0;
    n_out = 0;
    held = '0;
    for (int c = 0; c < 100 && (n < 10 || !all_empty()); c++) begin
      ivalid = (n < 10);
      in_a   = pack(n, n, n, n);
      in_b   = '0;
      oready = !(c >= 4 && c <= 8);
      tick();
      if (acc) n++;
      if (xfer[0]) begin
        check("bp_order", VW'(last_out0[0 +: SW]), VW'(n_out));
        n_out++;
      end
      if (c >= 4 && c <= 8) begin
        check("bp_stall_iready", VW'(iready[0]), VW'(0));
        check("bp_stall_ovalid", VW'(ovalid[0]), VW'(1));
        if (c == 4) held = out_v[0];
        else check("bp_stall_hold", out_v[0], held);
      end
    end
    check("bp_out_count", VW'(n_out), VW'(10));
    drain();

    // Frame done with NELEM=4: 9 beats after a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    k = 0;
    oready = 1'b1;
    for (int c = 0; c < 100 && k < 9; c++) begin
      ivalid = (n < 9);
      in_a   = pack(n, 1, 2, 3);
      in_b   = pack(1, 1, 1, 1);
      tick();
      if (acc) n++;
      if (xfer[0]) begin
        check("frame_beat_cnt", VW'(beat_cnt[0]), VW'((k + 1) % 4));
        check("frame_done", VW'(done[0]), VW'(((k + 1) % 4) == 0));
        k++;
      end
    end
    check("frame_beats", VW'(k), VW'(9));
    drain();

    // Reset mid-operation: beat_cnt=2 and two beats in flight
    send_beat(pack(1, 1, 1, 1), pack(2, 2, 2, 2));
    drain();
    check("mid_pre_cnt", VW'(beat_cnt[0]), VW'(2));
    ivalid = 1'b1;
    in_a   = pack(100, 101, 102, 103);
    in_b   = pack(1, 1, 1, 1);
    tick();
    check("mid_acc1", VW'(acc), VW'(1));
    in_a   = pack(200, 201, 202, 203);
    tick();
    check("mid_acc2", VW'(acc), VW'(1));
    ivalid = 1'b0;
    check("mid_inflight_ovalid", VW'(ovalid[0]), VW'(0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("mid_rst_ovalid[%0d]", d), VW'(ovalid[d]), VW'(0));
      check($sformatf("mid_rst_cnt[%0d]", d), VW'(beat_cnt[d]), VW'(0));
      check($sformatf("mid_rst_done[%0d]", d), VW'(done[d]), VW'(0));
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_no_ghost", VW'(ovalid[0]), VW'(0));
    end
    send_beat(pack(7, 8, 9, 10), pack(5, 6, 7, 8));
    tick();
    tick();
    check("mid_next_valid", VW'(ovalid[0]), VW'(1));
    check("mid_next_data", out_v[0], pack(12, 14, 16, 18));
    drain();
    check("mid_next_cnt", VW'(beat_cnt[0]), VW'(1));

    // Random traffic: 1000 beats, 50% ivalid and oready
    n = 0;
    for (int c = 0; c < 20000 && n < 1000; c++) begin
      ivalid = 1'($urandom_range(0, 1));
      oready = 1'($urandom_range(0, 1));
      in_a   = {$urandom, $urandom, $urandom, $urandom};
      in_b   = {$urandom, $urandom, $urandom, $urandom};
      tick();
      if (acc) n++;
    end
    check("rand_accepted", VW'(n), VW'(1000));
    drain();
    for (int d = 0; d < ND; d++)
      check($sformatf("rand_q_empty[%0d]", d), VW'(exp_q[d].size()), VW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
